alu_seq_112: RTL and testbench

//  Multi-precision sequencer for the 8-bit alu_112 datapath. It accepts an

---
 rtl/alu_seq_112_pkg.sv | 31 +++
 rtl/alu_112.sv | 47 ++++
 rtl/alu_seq_112.sv | 119 +++++++++++
 tb/tb_alu_seq_112.sv | 191 +++++++++++++++++++
 4 files changed

// File: rtl/alu_seq_112_pkg.sv
// rtl/alu_seq_112_pkg.sv - opcode constants, FSM states and opcode helpers for alu_seq_112
package alu_seq_112_pkg;

   // alu_112 opcodes
   localparam logic [2:0] OP_ADD  = 3'b000;
   localparam logic [2:0] OP_ADC  = 3'b001;
   localparam logic [2:0] OP_SBB  = 3'b010;
   localparam logic [2:0] OP_AND  = 3'b011;
   localparam logic [2:0] OP_OR   = 3'b100;
   localparam logic [2:0] OP_XOR  = 3'b101;
   localparam logic [2:0] OP_NOTA = 3'b110;
   localparam logic [2:0] OP_RSVD = 3'b111;

   // sequencer states
   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_RUN  = 2'd1,
      S_DONE = 2'd2
   } state_t;

   // arithmetic ops chain a carry/borrow between bytes
   function automatic logic is_arith(input logic [2:0] code);
      return (code == OP_ADD) || (code == OP_ADC) || (code == OP_SBB);
   endfunction

   // only adc and sbb take the external carry/borrow into byte 0
   function automatic logic uses_ci(input logic [2:0] code);
      return (code == OP_ADC) || (code == OP_SBB);
   endfunction

endpackage

// File: rtl/alu_112.sv
// rtl/alu_112.sv - combinational 8-bit ALU with carry/borrow in and out
module alu_112
   import alu_seq_112_pkg::*;
(
   input  logic [7:0] a,
   input  logic [7:0] b,
   input  logic [2:0] op,
   input  logic       ci,
   output logic [7:0] y,
   output logic       co
);

   logic [8:0] sum;
   logic [8:0] diff;

   // 9-bit add and subtract; bit 8 is carry-out or borrow-out respectively
   always_comb begin
      sum  = {1'b0, a} + {1'b0, b} + {8'b0, ci};
      diff = {1'b0, a} - {1'b0, b} - {8'b0, ci};
   end

   // opcode decode; logic ops and the reserved code never produce a carry
   always_comb begin
      y  = 8'h00;
      co = 1'b0;
      case (op)
         OP_ADD: begin
            y  = a + b;
            co = ({1'b0, a} + {1'b0, b}) > 9'd255;
         end
         OP_ADC: begin
            y  = sum[7:0];
            co = sum[8];
         end
         OP_SBB: begin
            y  = diff[7:0];
            co = diff[8];
         end
         OP_AND:  y = a & b;
         OP_OR:   y = a | b;
         OP_XOR:  y = a ^ b;
         OP_NOTA: y = ~a;
         default: y = 8'h00;
      endcase
   end

endmodule

// File: rtl/alu_seq_112.sv
// rtl/alu_seq_112.sv - multi-precision sequencer running alu_112 one byte per clock, LSB first
module alu_seq_112
   import alu_seq_112_pkg::*;
#(
   parameter  int NBYTES = 4,
   localparam int W      = 8 * NBYTES
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         start,
   input  logic [2:0]   op,
   input  logic [W-1:0] opa,
   input  logic [W-1:0] opb,
   input  logic         ci,
   output logic         busy,
   output logic         done,
   output logic         err,
   output logic [W-1:0] res,
   output logic         co
);

   localparam int IW = $clog2(NBYTES + 1);
   localparam logic [IW-1:0] LAST = IW'(NBYTES - 1);

   state_t         state_q;
   state_t         state_d;
   logic [IW-1:0]  idx_q;
   logic [2:0]     op_q;
   logic [W-1:0]   opa_q;
   logic [W-1:0]   opb_q;
   logic [W-1:0]   res_q;
   logic           carry_q;
   logic           err_q;

   logic           accept;
   logic           reject;
   logic [7:0]     alu_a;
   logic [7:0]     alu_b;
   logic [2:0]     alu_op;
   logic [7:0]     alu_y;
   logic           alu_co;

   // start is only looked at while not busy (IDLE or DONE)
   always_comb begin
      accept = start && (state_q != S_RUN) && (op != OP_RSVD);
      reject = start && (state_q != S_RUN) && (op == OP_RSVD);
   end

   // byte steering into the shared ALU; plain add runs as adc with a zero carry reg
   always_comb begin
      alu_a  = opa_q[8*idx_q +: 8];
      alu_b  = opb_q[8*idx_q +: 8];
      alu_op = (op_q == OP_ADD) ? OP_ADC : op_q;
   end

   alu_112 u_alu (
      .a  (alu_a),
      .b  (alu_b),
      .op (alu_op),
      .ci (carry_q),
      .y  (alu_y),
      .co (alu_co)
   );

   // state register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state_q <= S_IDLE;
      else        state_q <= state_d;
   end

   // next state: RUN leaves after the last byte; DONE may chain straight into RUN
   always_comb begin
      state_d = state_q;
      case (state_q)
         S_IDLE: if (accept) state_d = S_RUN;
         S_RUN:  if (idx_q == LAST) state_d = S_DONE;
         S_DONE: state_d = accept ? S_RUN : S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   // operand latch on accept, then one result byte and carry update per RUN cycle
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         idx_q   <= '0;
         op_q    <= OP_ADD;
         opa_q   <= '0;
         opb_q   <= '0;
         res_q   <= '0;
         carry_q <= 1'b0;
      end else if (accept) begin
         idx_q   <= '0;
         op_q    <= op;
         opa_q   <= opa;
         opb_q   <= opb;
         carry_q <= uses_ci(op) ? ci : 1'b0;
      end else if (state_q == S_RUN) begin
         res_q[8*idx_q +: 8] <= alu_y;
         carry_q             <= is_arith(op_q) ? alu_co : 1'b0;
         idx_q               <= idx_q + 1'b1;
      end
   end

   // reserved opcode while not busy raises a single-cycle error pulse
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) err_q <= 1'b0;
      else        err_q <= reject;
   end

   // outputs; co mirrors the carry reg, which holds its final value until the next accept
   always_comb begin
      busy = (state_q == S_RUN);
      done = (state_q == S_DONE);
      err  = err_q;
      res  = res_q;
      co   = carry_q;
   end

endmodule

// File: tb/tb_alu_seq_112.sv
// tb/tb_alu_seq_112.sv - directed table-driven bench for alu_seq_112 with NBYTES=4
module tb_alu_seq_112;

   typedef struct {
      string       name;
      logic [2:0]  op;
      logic [31:0] a;
      logic [31:0] b;
      logic        ci;
      logic [31:0] exp_res;
      logic        exp_co;
   } vec_t;

   logic        clk;
   logic        rst_n;
   logic        start;
   logic [2:0]  op;
   logic [31:0] opa;
   logic [31:0] opb;
   logic        ci;
   logic        busy;
   logic        done;
   logic        err;
   logic [31:0] res;
   logic        co;

   int checks;
   int errors;

   alu_seq_112 #(.NBYTES(4)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .start (start),
      .op    (op),
      .opa   (opa),
      .opb   (opb),
      .ci    (ci),
      .busy  (busy),
      .done  (done),
      .err   (err),
      .res   (res),
      .co    (co)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
      end
   endtask

   // called at a negedge; returns at the negedge after the accepting edge
   task automatic issue(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b, input logic c);
      start = 1'b1;
      op    = o;
      opa   = a;
      opb   = b;
      ci    = c;
      @(posedge clk);
      @(negedge clk);
      start = 1'b0;
   endtask

   // counts edges from the accepting edge (edge 1) until done is seen
   task automatic wait_done(output int edges);
      edges = 1;
      while (!done && edges < 40) begin
         @(posedge clk);
         @(negedge clk);
         edges++;
      end
   endtask

   vec_t vecs[7];
   int   edges;

   initial begin
      checks = 0;
      errors = 0;
      rst_n  = 1'b0;
      start  = 1'b0;
      op     = 3'b000;
      opa    = '0;
      opb    = '0;
      ci     = 1'b0;

      vecs[0] = '{"add_57_b1",   3'b000, 32'h00000057, 32'h000000B1, 1'b0, 32'h00000108, 1'b0};
      vecs[1] = '{"adc_wrap",    3'b001, 32'hFFFFFFFF, 32'h00000000, 1'b1, 32'h00000000, 1'b1};
      vecs[2] = '{"sbb_borrow",  3'b010, 32'h00000000, 32'h00000001, 1'b0, 32'hFFFFFFFF, 1'b1};
      vecs[3] = '{"and",         3'b011, 32'h57F15700, 32'hB1B1B1B1, 1'b1, 32'h11B11100, 1'b0};
      vecs[4] = '{"or",          3'b100, 32'h57F15700, 32'hB1B1B1B1, 1'b0, 32'hF7F1F7B1, 1'b0};
      vecs[5] = '{"xor",         3'b101, 32'h57F15700, 32'hB1B1B1B1, 1'b1, 32'hE640E6B1, 1'b0};
      vecs[6] = '{"nota",        3'b110, 32'h57F15700, 32'hB1B1B1B1, 1'b0, 32'hA80EA8FF, 1'b0};

      #12;
      check("rst_busy", 64'(busy), 64'd0);
      check("rst_done", 64'(done), 64'd0);
      check("rst_err",  64'(err),  64'd0);
      check("rst_res",  64'(res),  64'd0);
      check("rst_co",   64'(co),   64'd0);
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);

      for (int i = 0; i < 7; i++) begin
         issue(vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].ci);
         check({vecs[i].name, "_busy"}, 64'(busy), 64'd1);
         wait_done(edges);
         check({vecs[i].name, "_edges"}, 64'(edges), 64'd5);
         check({vecs[i].name, "_res"}, 64'(res), 64'(vecs[i].exp_res));
         check({vecs[i].name, "_co"}, 64'(co), 64'(vecs[i].exp_co));
         @(negedge clk);
         check({vecs[i].name, "_done_pulse"}, 64'(done), 64'd0);
      end

      // reserved opcode: err pulse, no state change, result held
      issue(3'b111, 32'h12345678, 32'h1, 1'b1);
      check("rsvd_err",  64'(err),  64'd1);
      check("rsvd_busy", 64'(busy), 64'd0);
      check("rsvd_res",  64'(res),  64'hA80EA8FF);
      @(negedge clk);
      check("rsvd_err_pulse", 64'(err), 64'd0);
      check("rsvd_done", 64'(done), 64'd0);

      // start pulsed mid-run must be ignored
      issue(3'b000, 32'h00000001, 32'h00000002, 1'b0);
      @(negedge clk);
      start = 1'b1;
      op    = 3'b101;
      opa   = 32'hFFFFFFFF;
      opb   = 32'h0F0F0F0F;
      @(negedge clk);
      start = 1'b0;
      edges = 3;
      while (!done && edges < 40) begin
         @(posedge clk);
         @(negedge clk);
         edges++;
      end
      check("midrun_edges", 64'(edges), 64'd5);
      check("midrun_res",   64'(res),   64'h00000003);
      check("midrun_co",    64'(co),    64'd0);
      @(negedge clk);
      check("midrun_idle",  64'(busy),  64'd0);

      // back-to-back: second start issued in the done cycle
      issue(3'b000, 32'h80000005, 32'h80000006, 1'b0);
      wait_done(edges);
      check("b2b1_edges", 64'(edges), 64'd5);
      check("b2b1_res",   64'(res),   64'h0000000B);
      check("b2b1_co",    64'(co),    64'd1);
      issue(3'b010, 32'h00000100, 32'h00000001, 1'b1);
      check("b2b2_busy",  64'(busy),  64'd1);
      check("b2b2_done",  64'(done),  64'd0);
      wait_done(edges);
      check("b2b2_edges", 64'(edges), 64'd5);
      check("b2b2_res",   64'(res),   64'h000000FE);
      check("b2b2_co",    64'(co),    64'd0);

      // async reset after two bytes of an adc that is carrying
      @(negedge clk);
      issue(3'b001, 32'hFFFFFFFF, 32'h00000000, 1'b1);
      @(posedge clk);
      @(posedge clk);
      #2;
      check("prerst_co", 64'(co), 64'd1);
      rst_n = 1'b0;
      #1;
      check("arst_busy", 64'(busy), 64'd0);
      check("arst_done", 64'(done), 64'd0);
      check("arst_res",  64'(res),  64'd0);
      check("arst_co",   64'(co),   64'd0);
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      check("postrst_busy", 64'(busy), 64'd0);
      issue(3'b001, 32'h12345678, 32'h11111111, 1'b1);
      wait_done(edges);
      check("postrst_edges", 64'(edges), 64'd5);
      check("postrst_res",   64'(res),   64'h2345678A);
      check("postrst_co",    64'(co),    64'd0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
